// File: rtl/queue_pkg.sv
// queue_pkg: default geometry shared by the queue and its users.
package queue_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
endpackage

// File: rtl/queue.sv
// queue: registered-output circular FIFO with an explicit occupancy counter and overflow pulse.
module queue
    import queue_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clock_1MHz,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       enqueue_in,
    input  logic                       dequeue_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH):0]     len_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic                       overflow_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_enq, do_deq;
    logic [LW-1:0]    len_nx;

    // A full queue still accepts a write when the same edge frees the head slot.
    always_comb begin
        do_deq = dequeue_in && !empty_out;
        do_enq = enqueue_in && (!full_out || dequeue_in);
        len_nx = len_out + LW'(do_enq) - LW'(do_deq);
    end

    always_ff @(posedge clock_1MHz)
        if (do_enq) mem[wr_ptr] <= data_in;

    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            len_out      <= '0;
            full_out     <= 1'b0;
            empty_out    <= 1'b1;
            data_out     <= '0;
            valid_out    <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + AW'(do_enq);
            rd_ptr       <= rd_ptr + AW'(do_deq);
            len_out      <= len_nx;
            full_out     <= len_nx == LW'(DEPTH);
            empty_out    <= len_nx == '0;
            data_out     <= do_deq ? mem[rd_ptr] : data_out;
            valid_out    <= do_deq;
            overflow_out <= enqueue_in && full_out && !dequeue_in;
        end
    end
endmodule

// File: tb/tb_queue.sv
// tb_queue: table-driven directed vectors for queue plus hand-written reset sequences.
module tb_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       enqueue_in, dequeue_in;
    logic [7:0] data_out;
    logic       valid_out, full_out, empty_out, overflow_out;
    logic [3:0] len_out;

    typedef struct {
        logic       enq;
        logic       deq;
        logic [7:0] din;
        logic [7:0] data;
        logic       valid;
        logic [3:0] len;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    queue #(.WIDTH(8), .DEPTH(8)) dut (
        .clock_1MHz  (clk),
        .rst         (rst),
        .data_in     (data_in),
        .enqueue_in  (enqueue_in),
        .dequeue_in  (dequeue_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .len_out     (len_out),
        .full_out    (full_out),
        .empty_out   (empty_out),
        .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    function automatic void v(logic e, logic q, logic [7:0] di, logic [7:0] d, logic vl, int l, logic ov);
        vec_t t;
        t.enq = e; t.deq = q; t.din = di; t.data = d; t.valid = vl; t.len = 4'(l); t.ovf = ov;
        vecs.push_back(t);
    endfunction

    task automatic check(string name, logic [7:0] d, logic vl, logic [3:0] l, logic ov);
        logic [15:0] got, exp;
        got = {data_out, valid_out, len_out, full_out, empty_out, overflow_out};
        exp = {d, vl, l, l == 4'd8, l == 4'd0, ov};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got data=%h valid=%b len=%0d full=%b empty=%b ovf=%b, expected data=%h valid=%b len=%0d full=%b empty=%b ovf=%b",
                     name, data_out, valid_out, len_out, full_out, empty_out, overflow_out,
                     d, vl, l, l == 4'd8, l == 4'd0, ov);
        end
    endtask

    initial begin
        rst = 1'b1; enqueue_in = 1'b0; dequeue_in = 1'b0; data_in = '0;

        v(0, 0, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) v(1, 0, 8'(i), 8'h00, 0, i + 1, 0);
        v(1, 0, 8'hAA, 8'h00, 0, 8, 1);
        v(0, 0, 8'h00, 8'h00, 0, 8, 0);
        for (int i = 0; i < 8; i++) v(0, 1, 8'h00, 8'(i), 1, 7 - i, 0);
        v(0, 1, 8'h00, 8'h07, 0, 0, 0);
        for (int i = 0; i < 5; i++) v(1, 0, 8'h20 + 8'(i), 8'h07, 0, i + 1, 0);
        for (int i = 0; i < 5; i++) v(0, 1, 8'h00, 8'h20 + 8'(i), 1, 4 - i, 0);
        for (int i = 0; i < 8; i++) v(1, 0, 8'h10 + 8'(i), 8'h24, 0, i + 1, 0);
        for (int i = 0; i < 8; i++) v(0, 1, 8'h00, 8'h10 + 8'(i), 1, 7 - i, 0);
        for (int i = 0; i < 8; i++) v(1, 0, 8'(i), 8'h17, 0, i + 1, 0);
        v(1, 1, 8'h55, 8'h00, 1, 8, 0);
        for (int i = 0; i < 7; i++) v(0, 1, 8'h00, 8'(i + 1), 1, 7 - i, 0);
        v(0, 1, 8'h00, 8'h55, 1, 0, 0);
        v(1, 1, 8'h66, 8'h55, 0, 1, 0);
        v(1, 1, 8'h77, 8'h66, 1, 1, 0);
        v(0, 1, 8'h00, 8'h77, 1, 0, 0);

        #1 check("reset_async", 8'h00, 0, 4'd0, 0);
        repeat (2) @(posedge clk);
        #1 check("reset_held", 8'h00, 0, 4'd0, 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            enqueue_in = vecs[k].enq;
            dequeue_in = vecs[k].deq;
            data_in    = vecs[k].din;
            @(posedge clk);
            #1 check($sformatf("vec%0d", k), vecs[k].data, vecs[k].valid, vecs[k].len, vecs[k].ovf);
        end

        enqueue_in = 1'b1; dequeue_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            data_in = 8'(i);
            @(posedge clk);
            #1;
        end
        enqueue_in = 1'b0;
        check("hold3", 8'h77, 0, 4'd3, 0);
        #2 rst = 1'b1;
        #1 check("rst_mid_cycle", 8'h00, 0, 4'd0, 0);
        @(negedge clk);
        rst = 1'b0; enqueue_in = 1'b1; data_in = 8'h99;
        @(posedge clk);
        #1 check("first_edge_after_rst", 8'h00, 0, 4'd1, 0);
        enqueue_in = 1'b0; dequeue_in = 1'b1;
        @(posedge clk);
        #1 check("post_rst_dequeue", 8'h99, 1, 4'd0, 0);
        dequeue_in = 1'b0;
        @(posedge clk);
        #1 check("valid_one_cycle", 8'h99, 0, 4'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/queue.md
QUEUE -- requirements
Module: queue

Interface
REQ-001 Parameter WIDTH, default 8, word width in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; SHALL be a power of two.
REQ-003 clock_1MHz  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  WIDTH  word from the upstream deserializer.
REQ-006 enqueue_in  input  1  write request; data_in is captured in the same cycle.
REQ-007 dequeue_in  input  1  read request.
REQ-008 data_out  output  WIDTH  last dequeued word, registered.
REQ-009 valid_out  output  1  one-cycle pulse: data_out updated this cycle.
REQ-010 len_out  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 full_out  output  1  high iff len_out == DEPTH.
REQ-012 empty_out  output  1  high iff len_out == 0.
REQ-013 overflow_out  output  1  one-cycle pulse: an enqueue was dropped.

Function
REQ-014 Each rising edge SHALL evaluate enqueue_in and dequeue_in once; a request held high for N cycles SHALL act as N requests.
REQ-015 Enqueue, not full: storage[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1 mod DEPTH.
REQ-016 Enqueue while full and no dequeue in the same cycle: word dropped, storage and pointers unchanged, overflow_out = 1 next cycle.
REQ-017 Dequeue, not empty: data_out <= storage[rd_ptr]; rd_ptr <= rd_ptr+1 mod DEPTH; valid_out = 1 for exactly that following cycle.
REQ-018 Dequeue while empty: ignored; data_out holds, valid_out stays 0.
REQ-019 Simultaneous enqueue and dequeue, 0 < len < DEPTH: both performed, len_out unchanged.
REQ-020 Simultaneous while empty: enqueue only, no bypass to data_out, len_out becomes 1.
REQ-021 Simultaneous while full: both performed (head read, new word written into the freed slot), no overflow, len_out stays DEPTH.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or reordering of data.
REQ-023 len_out, full_out and empty_out SHALL be registered and reflect the state after the edge's operations; latency from request to status change is 1 cycle.
REQ-024 Ordering SHALL be strict FIFO.

Reset
REQ-025 While rst = 1: wr_ptr = rd_ptr = 0, len_out = 0, empty_out = 1, full_out = 0, data_out = 0, valid_out = 0, overflow_out = 0.
REQ-026 Reset asserted mid-operation SHALL discard all stored words immediately; storage contents need not be cleared.
REQ-027 Requests sampled in the first edge after rst deasserts SHALL be honoured.

Structure
REQ-028 Package queue_pkg SHALL hold WIDTH/DEPTH defaults and PTR_W = $clog2(DEPTH).
REQ-029 Storage array, pointers and counter SHALL be inline; no sub-module is required.
REQ-030 Occupancy SHALL be held in an explicit counter, not derived from pointer difference.

Verification
REQ-031 Reset, then enqueue 0x00..0x07 on consecutive cycles -> len_out 8, full_out 1, no overflow_out.
REQ-032 Full queue, enqueue 0xAA -> overflow_out pulses once, len_out stays 8; subsequent 8 dequeues return 0x00..0x07 with valid_out on each.
REQ-033 Empty queue, dequeue -> valid_out 0, data_out unchanged, len_out 0.
REQ-034 Fill 5, dequeue 5, enqueue 0x10..0x17, dequeue 8 -> pointers wrap, outputs 0x10..0x17 in order.
REQ-035 Full queue, simultaneous enqueue 0x55 and dequeue -> data_out 0x00, len_out 8, no overflow; 0x55 emerges eighth.
REQ-036 Queue holding 3 words, rst pulsed mid-cycle -> len_out 0 and empty_out 1 immediately, before the next clock edge.
